// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock qualifier: retries on lock timeout, releases
// downstream domain resets in a staggered order, and re-sequences on lock loss.
module pll_lock_supervisor #(
    parameter int unsigned RST_PULSE_CYC    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYC = 27000,
    parameter int unsigned LOCK_STABLE_CYC  = 270,
    parameter int unsigned NCH              = 2,
    parameter int unsigned STAGGER_CYC      = 8,
    parameter int unsigned MAX_RETRY        = 7
) (
    input  logic           clkin,
    input  logic           reset,
    input  logic           pll_lock,
    input  logic           restart,
    output logic           pll_reset,
    output logic [NCH-1:0] rst_out,
    output logic           ready,
    output logic           fail,
    output logic [3:0]     retry_cnt,
    output logic [7:0]     loss_cnt
);

    localparam int unsigned REL_END = (NCH - 1) * STAGGER_CYC;
    localparam int unsigned PH_MAX  = (RST_PULSE_CYC > REL_END) ? RST_PULSE_CYC : REL_END;
    localparam int unsigned PH_W    = $clog2(PH_MAX + 1);
    localparam int unsigned TMR_W   = $clog2(LOCK_TIMEOUT_CYC + 1);
    localparam int unsigned STB_W   = $clog2(LOCK_STABLE_CYC + 1);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_RELEASE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sync_q;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [STB_W-1:0] stb_q, stb_d;
    logic [3:0]       retry_q, retry_d;
    logic [7:0]       loss_q, loss_d;
    logic             pll_reset_q, pll_reset_d;
    logic [NCH-1:0]   rst_out_q, rst_out_d;
    logic             ready_q, ready_d;
    logic             fail_q, fail_d;

    logic             lock_s;
    logic             timeout_c;
    logic [3:0]       retry_inc_c;
    logic [7:0]       loss_inc_c;

    // Two-flop synchroniser for the asynchronous lock indication
    always_ff @(posedge clkin) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_lock};
        end
    end

    assign lock_s      = sync_q[1];
    assign timeout_c   = (tmr_q == TMR_W'(LOCK_TIMEOUT_CYC - 1));
    assign retry_inc_c = (retry_q == 4'd15) ? retry_q : retry_q + 4'd1;
    assign loss_inc_c  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;

    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q     <= S_RESET_PLL;
            ph_q        <= '0;
            tmr_q       <= '0;
            stb_q       <= '0;
            retry_q     <= 4'd0;
            loss_q      <= 8'd0;
            pll_reset_q <= 1'b1;
            rst_out_q   <= '1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            tmr_q       <= tmr_d;
            stb_q       <= stb_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_reset_q <= pll_reset_d;
            rst_out_q   <= rst_out_d;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
        end
    end

    // Next state; outputs are registered from the next state so they change with it
    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        tmr_d       = tmr_q;
        stb_d       = stb_q;
        retry_d     = retry_q;
        loss_d      = loss_q;
        pll_reset_d = 1'b0;
        rst_out_d   = '1;
        ready_d     = 1'b0;
        fail_d      = 1'b0;

        case (state_q)
            S_RESET_PLL: begin
                tmr_d = '0;
                stb_d = '0;
                if (ph_q == PH_W'(RST_PULSE_CYC - 1)) begin
                    state_d = S_WAIT_LOCK;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            S_WAIT_LOCK, S_STABLE: begin
                tmr_d = tmr_q + TMR_W'(1);
                if (timeout_c) begin
                    retry_d = retry_inc_c;
                    tmr_d   = '0;
                    stb_d   = '0;
                    ph_d    = '0;
                    if (MAX_RETRY != 0 && 32'(retry_inc_c) == MAX_RETRY) begin
                        state_d = S_FAIL;
                    end else begin
                        state_d = S_RESET_PLL;
                    end
                end else if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    stb_d   = '0;
                end else if (stb_q + STB_W'(1) == STB_W'(LOCK_STABLE_CYC)) begin
                    state_d = (NCH == 1) ? S_RUN : S_RELEASE;
                    ph_d    = '0;
                    stb_d   = '0;
                end else begin
                    state_d = S_STABLE;
                    stb_d   = stb_q + STB_W'(1);
                end
            end
            S_RELEASE: begin
                if (!lock_s) begin
                    loss_d  = loss_inc_c;
                    state_d = S_RESET_PLL;
                    ph_d    = '0;
                end else if (ph_q + PH_W'(1) == PH_W'(REL_END)) begin
                    state_d = S_RUN;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    loss_d  = loss_inc_c;
                    state_d = S_RESET_PLL;
                    ph_d    = '0;
                end
            end
            S_FAIL: begin
            end
            default: begin
                state_d = S_RESET_PLL;
                ph_d    = '0;
            end
        endcase

        if (state_d == S_RUN && state_q != S_RUN) begin
            retry_d = 4'd0;
        end

        // Restart overrides every other transition but keeps loss history
        if (restart) begin
            state_d = S_RESET_PLL;
            ph_d    = '0;
            tmr_d   = '0;
            stb_d   = '0;
            retry_d = 4'd0;
            loss_d  = loss_q;
        end

        pll_reset_d = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
        fail_d      = (state_d == S_FAIL);
        ready_d     = (state_d == S_RUN);
        for (int unsigned i = 0; i < NCH; i++) begin
            rst_out_d[i] = !((state_d == S_RUN) ||
                             ((state_d == S_RELEASE) && (ph_d >= PH_W'(i * STAGGER_CYC))));
        end
    end

    assign pll_reset = pll_reset_q;
    assign rst_out   = rst_out_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;
    assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small parameters and
// hand-derived cycle-exact expectations.
module tb_pll_lock_supervisor;

    logic       clkin = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       restart;
    logic       pll_reset;
    logic [2:0] rst_out;
    logic       ready;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    pll_lock_supervisor #(
        .RST_PULSE_CYC   (4),
        .LOCK_TIMEOUT_CYC(50),
        .LOCK_STABLE_CYC (10),
        .NCH             (3),
        .STAGGER_CYC     (5),
        .MAX_RETRY       (2)
    ) dut (
        .clkin    (clkin),
        .reset    (reset),
        .pll_lock (pll_lock),
        .restart  (restart),
        .pll_reset(pll_reset),
        .rst_out  (rst_out),
        .ready    (ready),
        .fail     (fail),
        .retry_cnt(retry_cnt),
        .loss_cnt (loss_cnt)
    );

    always #5 clkin = ~clkin;

    task automatic tick();
        @(posedge clkin);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) tick();
    endtask

    // Leaves the bench at cycle 0: first cycle with reset low
    task automatic apply_reset();
        reset    = 1'b1;
        pll_lock = 1'b0;
        restart  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (pll_reset !== 1'b1) begin errors++; $display("FAIL reset_pll_reset got=%b exp=1", pll_reset); end
        checks++; if (rst_out !== 3'b111) begin errors++; $display("FAIL reset_rst_out got=%b exp=111", rst_out); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready); end
        checks++; if (fail !== 1'b0) begin errors++; $display("FAIL reset_fail got=%b exp=0", fail); end
        checks++; if (retry_cnt !== 4'd0) begin errors++; $display("FAIL reset_retry got=%0d exp=0", retry_cnt); end
        checks++; if (loss_cnt !== 8'd0) begin errors++; $display("FAIL reset_loss got=%0d exp=0", loss_cnt); end
        goto(3);
        checks++; if (pll_reset !== 1'b1) begin errors++; $display("FAIL reset_pulse_c3 got=%b exp=1", pll_reset); end
        goto(4);
        checks++; if (pll_reset !== 1'b0) begin errors++; $display("FAIL reset_pulse_c4 got=%b exp=0", pll_reset); end
    endtask

    task automatic test_nominal();
        logic [2:0] exp_rst;
        apply_reset();
        for (int c = 0; c <= 45; c++) begin
            goto(c);
            exp_rst = (c >= 42) ? 3'b000 : (c >= 37) ? 3'b100 : (c >= 32) ? 3'b110 : 3'b111;
            checks++; if (rst_out !== exp_rst) begin errors++; $display("FAIL nom_rst_out cyc=%0d got=%b exp=%b", c, rst_out, exp_rst); end
            checks++; if (ready !== 1'(c >= 42)) begin errors++; $display("FAIL nom_ready cyc=%0d got=%b exp=%b", c, ready, c >= 42); end
            checks++; if (pll_reset !== 1'(c < 4)) begin errors++; $display("FAIL nom_pll_reset cyc=%0d got=%b exp=%b", c, pll_reset, c < 4); end
            checks++; if (retry_cnt !== 4'd0) begin errors++; $display("FAIL nom_retry cyc=%0d got=%0d exp=0", c, retry_cnt); end
            if (c == 20) pll_lock = 1'b1;
        end
    endtask

    task automatic test_timeout_fail();
        logic       exp_pr;
        logic [3:0] exp_rc;
        apply_reset();
        for (int c = 0; c <= 130; c++) begin
            goto(c);
            exp_pr = (c < 4) || (c >= 54 && c < 58) || (c >= 108);
            exp_rc = (c >= 108) ? 4'd2 : (c >= 54) ? 4'd1 : 4'd0;
            checks++; if (pll_reset !== exp_pr) begin errors++; $display("FAIL to_pll_reset cyc=%0d got=%b exp=%b", c, pll_reset, exp_pr); end
            checks++; if (retry_cnt !== exp_rc) begin errors++; $display("FAIL to_retry cyc=%0d got=%0d exp=%0d", c, retry_cnt, exp_rc); end
            checks++; if (fail !== 1'(c >= 108)) begin errors++; $display("FAIL to_fail cyc=%0d got=%b exp=%b", c, fail, c >= 108); end
            checks++; if (rst_out !== 3'b111) begin errors++; $display("FAIL to_rst_out cyc=%0d got=%b exp=111", c, rst_out); end
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        checks++; if (fail !== 1'b0) begin errors++; $display("FAIL fail_restart_fail got=%b exp=0", fail); end
        checks++; if (pll_reset !== 1'b1) begin errors++; $display("FAIL fail_restart_pll_reset got=%b exp=1", pll_reset); end
        checks++; if (retry_cnt !== 4'd0) begin errors++; $display("FAIL fail_restart_retry got=%0d exp=0", retry_cnt); end
        goto(135);
        checks++; if (pll_reset !== 1'b0) begin errors++; $display("FAIL fail_restart_wait got=%b exp=0", pll_reset); end
    endtask

    task automatic test_chatter();
        logic [2:0] exp_rst;
        apply_reset();
        for (int c = 0; c <= 60; c++) begin
            goto(c);
            exp_rst = (c >= 39) ? 3'b000 : (c >= 34) ? 3'b100 : (c >= 29) ? 3'b110 : 3'b111;
            checks++; if (rst_out !== exp_rst) begin errors++; $display("FAIL chat_rst_out cyc=%0d got=%b exp=%b", c, rst_out, exp_rst); end
            checks++; if (ready !== 1'(c >= 39)) begin errors++; $display("FAIL chat_ready cyc=%0d got=%b exp=%b", c, ready, c >= 39); end
            checks++; if (pll_reset !== 1'(c < 4)) begin errors++; $display("FAIL chat_pll_reset cyc=%0d got=%b exp=%b", c, pll_reset, c < 4); end
            checks++; if (retry_cnt !== 4'd0) begin errors++; $display("FAIL chat_retry cyc=%0d got=%0d exp=0", c, retry_cnt); end
            if (c == 10) pll_lock = 1'b1;
            if (c == 16) pll_lock = 1'b0;
            if (c == 17) pll_lock = 1'b1;
        end
    endtask

    task automatic test_loss();
        logic [2:0] exp_rst;
        logic       exp_rdy;
        apply_reset();
        for (int c = 0; c <= 135; c++) begin
            goto(c);
            if (c < 32 || (c >= 103 && c < 122)) exp_rst = 3'b111;
            else if (c < 37 || (c >= 122 && c < 127)) exp_rst = 3'b110;
            else if (c < 42 || (c >= 127 && c < 132)) exp_rst = 3'b100;
            else exp_rst = 3'b000;
            exp_rdy = (c >= 42 && c < 103) || (c >= 132);
            checks++; if (rst_out !== exp_rst) begin errors++; $display("FAIL loss_rst_out cyc=%0d got=%b exp=%b", c, rst_out, exp_rst); end
            checks++; if (ready !== exp_rdy) begin errors++; $display("FAIL loss_ready cyc=%0d got=%b exp=%b", c, ready, exp_rdy); end
            checks++; if (pll_reset !== 1'(c < 4 || (c >= 103 && c < 107))) begin errors++; $display("FAIL loss_pll_reset cyc=%0d got=%b", c, pll_reset); end
            checks++; if (loss_cnt !== ((c >= 103) ? 8'd1 : 8'd0)) begin errors++; $display("FAIL loss_cnt cyc=%0d got=%0d exp=%0d", c, loss_cnt, c >= 103); end
            if (c == 20)  pll_lock = 1'b1;
            if (c == 100) pll_lock = 1'b0;
            if (c == 110) pll_lock = 1'b1;
        end
        goto(140);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        checks++; if (pll_reset !== 1'b1) begin errors++; $display("FAIL loss_restart_pll_reset got=%b exp=1", pll_reset); end
        checks++; if (rst_out !== 3'b111) begin errors++; $display("FAIL loss_restart_rst_out got=%b exp=111", rst_out); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL loss_restart_ready got=%b exp=0", ready); end
        checks++; if (loss_cnt !== 8'd1) begin errors++; $display("FAIL loss_restart_loss got=%0d exp=1", loss_cnt); end
    endtask

    task automatic test_restart();
        logic [2:0] exp_rst;
        apply_reset();
        for (int c = 0; c <= 55; c++) begin
            goto(c);
            if (c < 32 || (c >= 39 && c < 53)) exp_rst = 3'b111;
            else if (c < 37 || c >= 53) exp_rst = 3'b110;
            else exp_rst = 3'b100;
            checks++; if (rst_out !== exp_rst) begin errors++; $display("FAIL rs_rst_out cyc=%0d got=%b exp=%b", c, rst_out, exp_rst); end
            checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rs_ready cyc=%0d got=%b exp=0", c, ready); end
            checks++; if (pll_reset !== 1'(c < 4 || (c >= 39 && c < 43))) begin errors++; $display("FAIL rs_pll_reset cyc=%0d got=%b", c, pll_reset); end
            checks++; if (retry_cnt !== 4'd0) begin errors++; $display("FAIL rs_retry cyc=%0d got=%0d exp=0", c, retry_cnt); end
            checks++; if (loss_cnt !== 8'd0) begin errors++; $display("FAIL rs_loss cyc=%0d got=%0d exp=0", c, loss_cnt); end
            if (c == 20) pll_lock = 1'b1;
            restart = (c == 38);
        end
    endtask

    task automatic test_reset_mid_run();
        apply_reset();
        goto(20); pll_lock = 1'b1;
        goto(50); pll_lock = 1'b0;
        goto(55); pll_lock = 1'b1;
        goto(80);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL mid_ready got=%b exp=1", ready); end
        checks++; if (loss_cnt !== 8'd1) begin errors++; $display("FAIL mid_loss got=%0d exp=1", loss_cnt); end
        checks++; if (rst_out !== 3'b000) begin errors++; $display("FAIL mid_rst_out got=%b exp=000", rst_out); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (pll_reset !== 1'b1) begin errors++; $display("FAIL mid_rst_pll_reset got=%b exp=1", pll_reset); end
        checks++; if (rst_out !== 3'b111) begin errors++; $display("FAIL mid_rst_rst_out got=%b exp=111", rst_out); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got=%b exp=0", ready); end
        checks++; if (fail !== 1'b0) begin errors++; $display("FAIL mid_rst_fail got=%b exp=0", fail); end
        checks++; if (retry_cnt !== 4'd0) begin errors++; $display("FAIL mid_rst_retry got=%0d exp=0", retry_cnt); end
        checks++; if (loss_cnt !== 8'd0) begin errors++; $display("FAIL mid_rst_loss got=%0d exp=0", loss_cnt); end
        goto(84);
        checks++; if (pll_reset !== 1'b1) begin errors++; $display("FAIL mid_rst_pulse_end got=%b exp=1", pll_reset); end
        goto(85);
        checks++; if (pll_reset !== 1'b0) begin errors++; $display("FAIL mid_rst_wait got=%b exp=0", pll_reset); end
    endtask

    initial begin
        reset    = 1'b1;
        pll_lock = 1'b0;
        restart  = 1'b0;
        test_reset();
        test_nominal();
        test_timeout_fail();
        test_chatter();
        test_loss();
        test_restart();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Sequences the PLL reset, qualifies its lock output, retries on lock timeout, and releases NCH downstream domain resets in a staggered order once lock is stable. It sits between the rPLL wrapper and the design's reset tree, running on the free-running board reference clock. It also re-sequences automatically on loss of lock and reports retry and loss statistics.

## Interface
- RST_PULSE_CYC, 16: cycles pll_reset is held high per attempt (≥1)
- LOCK_TIMEOUT_CYC, 27000: cycles allowed per attempt to reach stable lock (1 ms at 27 MHz)
- LOCK_STABLE_CYC, 270: consecutive synchronised-lock-high cycles required (≥1)
- NCH, 2: number of downstream reset channels (1..8)
- STAGGER_CYC, 8: cycles between successive channel releases (≥1)
- MAX_RETRY, 7: timeouts before entering FAIL; 0 = retry forever
- clkin  in  1  reference clock, single clock domain
- reset  in  1  synchronous, active-high
- pll_lock  in  1  raw PLL lock, asynchronous
- restart  in  1  one-cycle pulse: abort and re-sequence from RESET_PLL
- pll_reset  out  1  drives PLL RESET
- rst_out  out  NCH  per-channel active-high domain resets
- ready  out  1  all channels released, lock good
- fail  out  1  retry budget exhausted
- retry_cnt  out  4  timeouts since last RUN entry, saturating at 15
- loss_cnt  out  8  lock losses in RUN since reset, saturating at 255

## Operation
- pll_lock passes through a 2-FF synchroniser (lock_s), reset to 0; lock_s = pll_lock delayed 2 cycles.
- States: RESET_PLL, WAIT_LOCK, STABLE, RELEASE, RUN, FAIL.
- RESET_PLL: pll_reset=1 for RST_PULSE_CYC cycles, then WAIT_LOCK. Attempt timer cleared on entry.
- WAIT_LOCK: pll_reset=0; lock_s=1 → STABLE. Attempt timer runs.
- STABLE: counts consecutive lock_s=1 samples, counting the sample that caused the WAIT_LOCK exit. Reaching LOCK_STABLE_CYC → RELEASE. lock_s=0 → WAIT_LOCK with the stable count cleared. The attempt timer keeps running, so chatter cannot stall it.
- Timeout: the attempt timer reaches LOCK_TIMEOUT_CYC in WAIT_LOCK or STABLE.
  - retry_cnt increments.
  - If MAX_RETRY≠0 and the new retry_cnt = MAX_RETRY → FAIL; otherwise → RESET_PLL.
- RELEASE: rst_out[i] deasserts at entry + i·STAGGER_CYC, in ascending order; after rst_out[NCH-1] deasserts → RUN. lock_s=0 in RELEASE counts as a loss, handled as in RUN.
- RUN: ready=1. retry_cnt clears on entry. lock_s=0 → loss_cnt increments, RESET_PLL.
- FAIL: pll_reset=1, fail=1, rst_out all 1. Exits only via reset or restart.
- restart takes priority over all transitions in every state:
  - next state RESET_PLL; retry_cnt cleared; loss_cnt unchanged.
  - rst_out all 1 and ready=0 from the next cycle.
- Whenever the state leaves RELEASE/RUN, all rst_out reassert and ready drops in the same cycle as the state change.

## Timing
- Reset values: pll_reset=1, rst_out all 1, ready=0, fail=0, retry_cnt=0, loss_cnt=0, state RESET_PLL, synchroniser 0.
- All outputs are registered.
- Cycle 0 is the first cycle with reset low:
  - pll_reset=1 for cycles 0..RST_PULSE_CYC-1.
  - pll_reset=0 from cycle RST_PULSE_CYC, when WAIT_LOCK begins.
- pll_lock rises at edge e and stays high:
  - rst_out[0] falls at e+2+LOCK_STABLE_CYC.
  - rst_out[i] falls i·STAGGER_CYC later.
  - ready rises in the same cycle as rst_out[NCH-1] falls.
- Timeout: pll_reset rises LOCK_TIMEOUT_CYC cycles after WAIT_LOCK entry.
- Loss: pll_lock falls at edge f in RUN.
  - rst_out all 1, ready=0, pll_reset=1 at f+3.
  - loss_cnt updates in the same cycle.
- Counter saturation: retry_cnt holds at 15; loss_cnt holds at 255.

## Test plan
Bench parameters: RST_PULSE_CYC=4, LOCK_TIMEOUT_CYC=50, LOCK_STABLE_CYC=10, NCH=3, STAGGER_CYC=5, MAX_RETRY=2. Cycle 0 = first cycle with reset low.
- Nominal: pll_lock rises at cycle 20 → pll_reset=1 for cycles 0–3; rst_out[0] falls at 32, [1] at 37, [2] at 42; ready=1 from 42; retry_cnt=0.
- Timeout to FAIL: pll_lock held 0 → pll_reset rises at 54 with retry_cnt=1; FAIL at 108 with fail=1, retry_cnt=2, pll_reset=1 held, rst_out=3'b111.
- Chatter: pll_lock high at 10, low for one cycle at 16, high from 17 → rst_out[0] falls at 29, not 22; no timeout.
- Loss in RUN: after the nominal sequence, pll_lock falls at 100 → at 103 rst_out=3'b111, ready=0, pll_reset=1, loss_cnt=1; relock re-releases normally.
- Restart: pulse restart at 38 during RELEASE → from 39 rst_out=3'b111, ready=0, pll_reset=1 for 4 cycles; retry_cnt=0; loss_cnt unchanged.
- Reset mid-RUN: assert reset for 1 cycle → every output returns to its reset value, including loss_cnt=0.
